// File: rtl/input_debouncer.sv
// input_debouncer: synchronises a raw asynchronous level into CLK and
// propagates it only after it has held a new value for STABLE_CYCLES
// consecutive synchronised samples. Aborted qualifications raise a
// one-cycle GLITCH_OUT pulse for diagnostics.
module input_debouncer #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic ASYNC_IN,
  output logic LEVEL_OUT,
  output logic BUSY_OUT,
  output logic GLITCH_OUT
);

  localparam int              CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE,
    ST_FILTER
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_q;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_busy;
  logic                   r_glitch;

  assign w_sync_q   = r_sync[SYNC_STAGES-1];
  assign LEVEL_OUT  = r_level;
  assign BUSY_OUT   = r_busy;
  assign GLITCH_OUT = r_glitch;

  // Synchroniser shift chain; only the last stage is consumed downstream.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ASYNC_IN};
    end
  end

  // Qualification FSM with registered level, busy and glitch outputs.
  // r_busy is updated together with r_state so it always equals (state == FILTER).
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_STABLE;
      r_cnt    <= '0;
      r_level  <= RESET_LEVEL;
      r_busy   <= 1'b0;
      r_glitch <= 1'b0;
    end else begin
      r_glitch <= 1'b0;
      case (r_state)
        ST_STABLE: begin
          if (w_sync_q != r_level) begin
            if (STABLE_CYCLES == 1) begin
              r_level <= w_sync_q;
            end else begin
              r_state <= ST_FILTER;
              r_cnt   <= CW'(1);
              r_busy  <= 1'b1;
            end
          end
        end
        ST_FILTER: begin
          if (w_sync_q == r_level) begin
            r_state  <= ST_STABLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_glitch <= 1'b1;
          end else if (r_cnt == LAST) begin
            r_level <= w_sync_q;
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_STABLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: two instances (STABLE_CYCLES 4 and 1) share
// the same stimulus; a run-length reference model predicts both.
module tb_input_debouncer;

  localparam int   SYNC = 2;
  localparam int   SCA  = 4;
  localparam int   SCB  = 1;
  localparam logic RL   = 1'b0;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ASYNC_IN = 1'b0;
  logic lvl0, busy0, gl0;
  logic lvl1, busy1, gl1;

  int n_checks = 0;
  int n_fail   = 0;
  int ecount   = 0;

  // reference model: delayed samples plus a run length per instance
  bit mq[$];
  bit m_lvl[2];
  int m_run[2];
  bit m_gl[2];

  input_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(SCA), .RESET_LEVEL(RL)) dut (
    .CLK(CLK), .RST(RST), .ASYNC_IN(ASYNC_IN),
    .LEVEL_OUT(lvl0), .BUSY_OUT(busy0), .GLITCH_OUT(gl0)
  );

  input_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(SCB), .RESET_LEVEL(RL)) dut1 (
    .CLK(CLK), .RST(RST), .ASYNC_IN(ASYNC_IN),
    .LEVEL_OUT(lvl1), .BUSY_OUT(busy1), .GLITCH_OUT(gl1)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // drive one cycle of stimulus, advance the model, settle 1ns past the edge
  task automatic tick(input logic a, input logic r);
    bit s;
    @(negedge CLK);
    ASYNC_IN = a;
    RST = r;
    @(posedge CLK);
    ecount++;
    if (r) begin
      mq.delete();
      repeat (SYNC) mq.push_back(RL);
      for (int c = 0; c < 2; c++) begin
        m_lvl[c] = RL; m_run[c] = 0; m_gl[c] = 1'b0;
      end
    end else begin
      s = mq.pop_front();
      mq.push_back(a);
      for (int c = 0; c < 2; c++) begin
        int sc;
        sc = (c == 0) ? SCA : SCB;
        m_gl[c] = 1'b0;
        if (s != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] >= sc) begin
            m_lvl[c] = s;
            m_run[c] = 0;
          end
        end else if (m_run[c] > 0) begin
          m_gl[c] = 1'b1;
          m_run[c] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      n_checks++;
      if ({lvl0, busy0, gl0, lvl1, busy1, gl1} !== 6'b000000) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: got %b expected 000000", i,
                 {lvl0, busy0, gl0, lvl1, busy1, gl1});
      end
    end
    tick(1'b1, 1'b0);
    n_checks++;
    if ({lvl0, busy0, gl0, lvl1, busy1, gl1} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected 000000",
               {lvl0, busy0, gl0, lvl1, busy1, gl1});
    end
  endtask

  task automatic test_clean_edge(input logic v);
    logic [2:0] exp;
    repeat (10) tick(~v, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(v, 1'b0);
      exp = {(i >= SYNC + SCA - 1) ? v : ~v,
             (i >= SYNC && i <= SYNC + SCA - 2), 1'b0};
      n_checks++;
      if ({lvl0, busy0, gl0} !== exp) begin
        n_fail++;
        $display("FAIL clean_edge v=%0b E%0d: lvl/busy/gl got %b expected %b",
                 v, i, {lvl0, busy0, gl0}, exp);
      end
    end
  endtask

  task automatic test_glitch();
    int bcnt, gcnt;
    bcnt = 0; gcnt = 0;
    repeat (10) tick(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick((i < 3) ? 1'b1 : 1'b0, 1'b0);
      bcnt += int'(busy0);
      gcnt += int'(gl0);
      n_checks++;
      if (lvl0 !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_level E%0d: got %b expected 0", i, lvl0);
      end
    end
    n_checks++;
    if (bcnt != 3) begin
      n_fail++;
      $display("FAIL glitch_busy_cycles: got %0d expected 3", bcnt);
    end
    n_checks++;
    if (gcnt != 1) begin
      n_fail++;
      $display("FAIL glitch_pulses: got %0d expected 1", gcnt);
    end
  endtask

  task automatic test_bounce();
    bit stim[$];
    int t0, changes, chg_k, dg, mg, w;
    logic prev;
    repeat (10) tick(1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      w = $urandom_range(1, 2);
      repeat (w) stim.push_back(1'b1);
      stim.push_back(1'b0);
    end
    t0 = stim.size();
    repeat (12) stim.push_back(1'b1);
    changes = 0; chg_k = -1; dg = 0; mg = 0;
    prev = lvl0;
    for (int k = 0; k < stim.size(); k++) begin
      tick(stim[k], 1'b0);
      dg += int'(gl0);
      mg += int'(m_gl[0]);
      if (lvl0 !== prev) begin
        changes++;
        chg_k = k;
      end
      prev = lvl0;
    end
    n_checks++;
    if (changes != 1) begin
      n_fail++;
      $display("FAIL bounce_changes: got %0d expected 1", changes);
    end
    n_checks++;
    if (chg_k != t0 + SYNC + SCA - 1) begin
      n_fail++;
      $display("FAIL bounce_latency: change at %0d expected %0d", chg_k, t0 + SYNC + SCA - 1);
    end
    n_checks++;
    if (dg != mg || dg != 5) begin
      n_fail++;
      $display("FAIL bounce_glitches: got %0d expected %0d (5 aborts)", dg, mg);
    end
  endtask

  task automatic test_stable_one();
    logic v;
    for (int d = 0; d < 2; d++) begin
      v = (d == 0) ? 1'b1 : 1'b0;
      repeat (6) tick(~v, 1'b0);
      for (int i = 0; i < 6; i++) begin
        tick(v, 1'b0);
        n_checks++;
        if ({lvl1, busy1, gl1} !== {((i >= SYNC) ? v : ~v), 2'b00}) begin
          n_fail++;
          $display("FAIL sc1_step v=%0b E%0d: got %b expected %b", v, i,
                   {lvl1, busy1, gl1}, {((i >= SYNC) ? v : ~v), 2'b00});
        end
      end
    end
  endtask

  task automatic test_reset_mid_filter();
    logic [2:0] exp;
    repeat (10) tick(1'b0, 1'b0);
    repeat (4) tick(1'b1, 1'b0);
    n_checks++;
    if ({lvl0, busy0, gl0} !== 3'b010) begin
      n_fail++;
      $display("FAIL midrst_pre: got %b expected 010", {lvl0, busy0, gl0});
    end
    tick(1'b1, 1'b1);
    n_checks++;
    if ({lvl0, busy0, gl0} !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_reset: got %b expected 000", {lvl0, busy0, gl0});
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0);
      exp = {(i >= SYNC + SCA - 1), (i >= SYNC && i <= SYNC + SCA - 2), 1'b0};
      n_checks++;
      if ({lvl0, busy0, gl0} !== exp) begin
        n_fail++;
        $display("FAIL midrst_restart E%0d: got %b expected %b", i, {lvl0, busy0, gl0}, exp);
      end
    end
  endtask

  task automatic test_random();
    int start, len;
    logic v, r;
    logic [5:0] exp;
    start = ecount;
    while (ecount < start + 600) begin
      v = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      r = ($urandom_range(0, 49) == 0);
      for (int j = 0; j < len; j++) begin
        tick(v, r && (j == 0));
        exp = {m_lvl[0], (m_run[0] > 0), m_gl[0], m_lvl[1], (m_run[1] > 0), m_gl[1]};
        n_checks++;
        if ({lvl0, busy0, gl0, lvl1, busy1, gl1} !== exp) begin
          n_fail++;
          $display("FAIL random cyc%0d: got %b expected %b", ecount,
                   {lvl0, busy0, gl0, lvl1, busy1, gl1}, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_edge(1'b1);
    test_clean_edge(1'b0);
    test_glitch();
    test_bounce();
    test_stable_one();
    test_reset_mid_filter();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
